// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  // Sequencer phases: one idle cycle after reset, then fetch/execute until halted.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } seqState_e;

  // Reason reported alongside a trap-halt.
  typedef enum logic [1:0] {
    TRAP_NONE     = 2'b00,
    TRAP_FETCH_TO = 2'b01,
    TRAP_MISALIGN = 2'b10
  } trapCause_e;

  // Every instruction is one 32-bit word.
  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of the instruction-memory handshake and the datapath control/status
// signals seen by the sequencer. The master side is the sequencer itself; the
// slave side is whatever drives imem and the decode/branch datapath.
interface pc_sequencer_if;

  // Instruction memory fetch handshake
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Instruction handed to decode
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] link_addr;

  // Retire information from the datapath
  logic        ex_retire;
  logic        is_branch;
  logic        br_taken;
  logic        is_jal;
  logic        is_jalr;
  logic [31:0] imm;
  logic [31:0] jalr_base;
  logic        halt_req;

  // Status
  logic        halted;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] retired_count;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, link_addr,
           halted, trap, trap_cause, retired_count,
    input  imem_ack, imem_rdata, ex_retire, is_branch, br_taken,
           is_jal, is_jalr, imm, jalr_base, halt_req
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, link_addr,
           halted, trap, trap_cause, retired_count,
    output imem_ack, imem_rdata, ex_retire, is_branch, br_taken,
           is_jal, is_jalr, imm, jalr_base, halt_req
  );

endinterface

// File: rtl/pc_next_calc.sv
// Next-PC selection for a retiring instruction. JALR beats JAL beats a taken
// conditional branch; everything else falls through to the next word. The
// alignment flag lets the sequencer trap instead of jumping into the middle
// of a word.
module pc_next_calc
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] jalrBase_i,
  input  logic        isBranch_i,
  input  logic        brTaken_i,
  input  logic        isJal_i,
  input  logic        isJalr_i,
  output logic [31:0] target_o,
  output logic        misaligned_o
);

  // Priority select of the jump/branch target; JALR clears bit 0 of its sum.
  always_comb begin
    target_o = pc_i + INSTR_BYTES;
    if (isJalr_i) begin
      target_o = (jalrBase_i + imm_i) & ~32'd1;
    end else if (isJal_i) begin
      target_o = pc_i + imm_i;
    end else if (isBranch_i && brTaken_i) begin
      target_o = pc_i + imm_i;
    end
  end

  assign misaligned_o = |target_o[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: runs the imem fetch handshake, holds the fetched
// instruction for the datapath while it executes, and on retire moves the PC
// to the selected target. Fetch timeouts and misaligned targets halt with a
// trap; a halt request halts cleanly. Only reset leaves HALT.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  localparam int              CNT_W    = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  seqState_e        state_q;
  logic [31:0]      pc_q;
  logic [31:0]      instr_q;
  logic             imemReq_q;
  logic             instrValid_q;
  logic             halted_q;
  logic             trap_q;
  trapCause_e       trapCause_q;
  logic [31:0]      retiredCount_q;
  logic [CNT_W-1:0] timeoutCnt_q;

  logic [31:0]      pcTarget_d;
  logic             pcMisaligned_d;

  pc_next_calc u_nextCalc (
    .pc_i         (pc_q),
    .imm_i        (bus.imm),
    .jalrBase_i   (bus.jalr_base),
    .isBranch_i   (bus.is_branch),
    .brTaken_i    (bus.br_taken),
    .isJal_i      (bus.is_jal),
    .isJalr_i     (bus.is_jalr),
    .target_o     (pcTarget_d),
    .misaligned_o (pcMisaligned_d)
  );

  // Sequencer FSM with all status outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      instr_q        <= '0;
      imemReq_q      <= 1'b0;
      instrValid_q   <= 1'b0;
      halted_q       <= 1'b0;
      trap_q         <= 1'b0;
      trapCause_q    <= TRAP_NONE;
      retiredCount_q <= '0;
      timeoutCnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q   <= FETCH;
          imemReq_q <= 1'b1;
        end

        FETCH: begin
          if (bus.imem_ack) begin
            instr_q      <= bus.imem_rdata;
            timeoutCnt_q <= '0;
            imemReq_q    <= 1'b0;
            instrValid_q <= 1'b1;
            state_q      <= EXEC;
          end else if (timeoutCnt_q == CNT_LAST) begin
            imemReq_q   <= 1'b0;
            halted_q    <= 1'b1;
            trap_q      <= 1'b1;
            trapCause_q <= TRAP_FETCH_TO;
            state_q     <= HALT;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + 1'b1;
          end
        end

        EXEC: begin
          if (bus.ex_retire) begin
            instrValid_q <= 1'b0;
            if (bus.halt_req) begin
              halted_q       <= 1'b1;
              retiredCount_q <= retiredCount_q + 32'd1;
              state_q        <= HALT;
            end else if (pcMisaligned_d) begin
              halted_q    <= 1'b1;
              trap_q      <= 1'b1;
              trapCause_q <= TRAP_MISALIGN;
              state_q     <= HALT;
            end else begin
              pc_q           <= pcTarget_d;
              retiredCount_q <= retiredCount_q + 32'd1;
              imemReq_q      <= 1'b1;
              state_q        <= FETCH;
            end
          end
        end

        HALT: begin
          state_q <= HALT;
        end

        default: begin
          state_q <= HALT;
        end
      endcase
    end
  end

  assign bus.imem_req      = imemReq_q;
  assign bus.imem_addr     = pc_q;
  assign bus.instr         = instr_q;
  assign bus.instr_valid   = instrValid_q;
  assign bus.pc            = pc_q;
  assign bus.link_addr     = pc_q + INSTR_BYTES;
  assign bus.halted        = halted_q;
  assign bus.trap          = trap_q;
  assign bus.trap_cause    = trapCause_q;
  assign bus.retired_count = retiredCount_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Expected fetch addresses go into a queue
// when a retire is driven and are checked when the sequencer raises imem_req.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam logic [31:0] RESET_PC      = 32'h0000_0000;
  localparam int          FETCH_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int testsRun = 0;
  int testsFailed = 0;
  logic [31:0] expAddrQ [$];

  pc_sequencer_if bus();

  pc_sequencer #(
    .RESET_PC      (RESET_PC),
    .FETCH_TIMEOUT (FETCH_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Hard stop in case something wedges the directed sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.ex_retire  = 1'b0;
    bus.is_branch  = 1'b0;
    bus.br_taken   = 1'b0;
    bus.is_jal     = 1'b0;
    bus.is_jalr    = 1'b0;
    bus.imm        = '0;
    bus.jalr_base  = '0;
    bus.halt_req   = 1'b0;
  endtask

  task automatic applyReset(input string tag);
    rst = 1'b1;
    clearInputs();
    expAddrQ.delete();
    stepClk();
    checkOutput({tag, "_pc"}, bus.pc, RESET_PC);
    checkOutput({tag, "_instr"}, bus.instr, 32'h0);
    checkOutput({tag, "_flags"},
                {26'd0, bus.imem_req, bus.instr_valid, bus.halted, bus.trap, bus.trap_cause}, 32'h0);
    checkOutput({tag, "_count"}, bus.retired_count, 32'h0);
    rst = 1'b0;
    expAddrQ.push_back(RESET_PC);
  endtask

  // Wait (bounded) for a fetch request, score its address, optionally ack it.
  task automatic fetchInstr(input string tag, input logic [31:0] word, input bit doAck);
    int waitCycles = 0;
    while (bus.imem_req !== 1'b1 && waitCycles < 20) begin
      stepClk();
      waitCycles++;
    end
    checkOutput({tag, "_req"}, 32'(bus.imem_req), 32'd1);
    checkOutput({tag, "_sbNonEmpty"}, 32'(expAddrQ.size() != 0), 32'd1);
    if (expAddrQ.size() != 0) begin
      checkOutput({tag, "_addr"}, bus.imem_addr, expAddrQ.pop_front());
    end
    if (doAck) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = word;
      stepClk();
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = ~word;
      checkOutput({tag, "_instr"}, bus.instr, word);
      checkOutput({tag, "_validReqOff"}, {30'd0, bus.instr_valid, bus.imem_req}, 32'h2);
    end
  endtask

  // Drive one retire pulse; queue the expected next fetch address if any.
  task automatic applyStimulus(input string tag, input bit isBr, input bit brTk, input bit jal,
                               input bit jalr, input bit haltR, input logic [31:0] immV,
                               input logic [31:0] baseV, input bit expectFetch,
                               input logic [31:0] expNext);
    bus.is_branch = isBr;
    bus.br_taken  = brTk;
    bus.is_jal    = jal;
    bus.is_jalr   = jalr;
    bus.halt_req  = haltR;
    bus.imm       = immV;
    bus.jalr_base = baseV;
    bus.ex_retire = 1'b1;
    if (expectFetch) expAddrQ.push_back(expNext);
    stepClk();
    clearInputs();
    checkOutput({tag, "_validLow"}, 32'(bus.instr_valid), 32'd0);
  endtask

  initial begin
    clearInputs();

    // Straight-line code: 0 -> 4 -> 8 -> C.
    applyReset("rstA");
    for (int i = 0; i < 3; i++) begin
      fetchInstr($sformatf("seqF%0d", i), 32'h0000_0013 + 32'(i), 1'b1);
      applyStimulus($sformatf("seqR%0d", i), 0, 0, 0, 0, 0, 32'h0, 32'h0, 1'b1, 32'(4 * (i + 1)));
    end
    fetchInstr("seqF3", 32'h0000_0093, 1'b1);
    checkOutput("seqCount", bus.retired_count, 32'd3);
    checkOutput("seqPc", bus.pc, 32'h0000_000C);

    // Instruction must stay put while EXEC waits for retire.
    stepClk();
    stepClk();
    checkOutput("instrHold", bus.instr, 32'h0000_0093);
    checkOutput("validHold", 32'(bus.instr_valid), 32'd1);

    // Branches: taken backwards from 0x10, then not taken, then br_taken without is_branch.
    applyStimulus("toTen", 0, 0, 0, 0, 0, 32'h0, 32'h0, 1'b1, 32'h0000_0010);
    fetchInstr("fTen", 32'h0000_0063, 1'b1);
    applyStimulus("brTaken", 1, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, 1'b1, 32'h0000_0008);
    fetchInstr("fEight", 32'h0000_0013, 1'b1);
    applyStimulus("toC", 0, 0, 0, 0, 0, 32'h0, 32'h0, 1'b1, 32'h0000_000C);
    fetchInstr("fC", 32'h0000_0013, 1'b1);
    applyStimulus("toTen2", 0, 0, 0, 0, 0, 32'h0, 32'h0, 1'b1, 32'h0000_0010);
    fetchInstr("fTen2", 32'h0000_0063, 1'b1);
    applyStimulus("brNotTaken", 1, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, 1'b1, 32'h0000_0014);
    fetchInstr("f14", 32'h0000_0013, 1'b1);
    applyStimulus("brIgnored", 0, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, 1'b1, 32'h0000_0018);
    fetchInstr("f18", 32'h0000_0067, 1'b1);
    checkOutput("link18", bus.link_addr, 32'h0000_001C);

    // JALR wins over JAL and clears bit 0; then JAL back to 0x10.
    applyStimulus("jalrPrio", 0, 0, 1, 1, 0, 32'h0, 32'h0000_0201, 1'b1, 32'h0000_0200);
    fetchInstr("f200", 32'h0000_006F, 1'b1);
    applyStimulus("jalBack", 0, 0, 1, 0, 0, 32'hFFFF_FE10, 32'h0, 1'b1, 32'h0000_0010);
    fetchInstr("fTen3", 32'h0000_0067, 1'b1);
    checkOutput("countEleven", bus.retired_count, 32'd11);
    checkOutput("linkTen", bus.link_addr, 32'h0000_0014);

    // JALR to 0x102 is not word aligned: trap, pc frozen, not counted.
    applyStimulus("jalrMis", 0, 0, 0, 1, 0, 32'h0000_0002, 32'h0000_0101, 1'b0, 32'h0);
    checkOutput("jalrMisStatus", {28'd0, bus.halted, bus.trap, bus.trap_cause}, 32'hE);
    checkOutput("jalrMisPc", bus.pc, 32'h0000_0010);
    checkOutput("jalrMisCount", bus.retired_count, 32'd11);

    // Stray ack/retire while halted change nothing.
    bus.imem_ack  = 1'b1;
    bus.ex_retire = 1'b1;
    stepClk();
    stepClk();
    clearInputs();
    checkOutput("strayPc", bus.pc, 32'h0000_0010);
    checkOutput("strayCount", bus.retired_count, 32'd11);
    checkOutput("strayFlags", {29'd0, bus.imem_req, bus.instr_valid, bus.halted}, 32'h1);

    // JAL by +6 from 0 is misaligned.
    applyReset("rstB");
    fetchInstr("fB", 32'h0060_006F, 1'b1);
    applyStimulus("jalMis", 0, 0, 1, 0, 0, 32'h0000_0006, 32'h0, 1'b0, 32'h0);
    checkOutput("jalMisStatus", {28'd0, bus.halted, bus.trap, bus.trap_cause}, 32'hE);
    checkOutput("jalMisPc", bus.pc, 32'h0);
    checkOutput("jalMisCount", bus.retired_count, 32'd0);

    // Halt request outranks a jump; it is counted and is not a trap.
    applyReset("rstC");
    fetchInstr("fC0", 32'h0010_0073, 1'b1);
    applyStimulus("haltReq", 0, 0, 1, 0, 1, 32'h0000_0008, 32'h0, 1'b0, 32'h0);
    checkOutput("haltStatus", {28'd0, bus.halted, bus.trap, bus.trap_cause}, 32'h8);
    checkOutput("haltPc", bus.pc, 32'h0);
    checkOutput("haltCount", bus.retired_count, 32'd1);
    bus.imem_ack  = 1'b1;
    bus.ex_retire = 1'b1;
    stepClk();
    stepClk();
    stepClk();
    clearInputs();
    checkOutput("haltStrayPc", bus.pc, 32'h0);
    checkOutput("haltStrayCount", bus.retired_count, 32'd1);
    checkOutput("haltStrayFlags", {29'd0, bus.imem_req, bus.instr_valid, bus.halted}, 32'h1);

    // Fetch timeout: no ack for FETCH_TIMEOUT cycles.
    applyReset("rstD");
    fetchInstr("fD", 32'h0, 1'b0);
    for (int i = 0; i < FETCH_TIMEOUT - 1; i++) stepClk();
    checkOutput("toNotYet", {30'd0, bus.imem_req, bus.halted}, 32'h2);
    stepClk();
    checkOutput("toStatus", {27'd0, bus.imem_req, bus.halted, bus.trap, bus.trap_cause}, 32'h0D);

    // Reset during FETCH with a simultaneous ack wins.
    applyReset("rstE");
    fetchInstr("fE0", 32'h0000_0013, 1'b1);
    applyStimulus("eR", 0, 0, 0, 0, 0, 32'h0, 32'h0, 1'b1, 32'h0000_0004);
    fetchInstr("fE1", 32'h0, 1'b0);
    rst            = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    stepClk();
    rst = 1'b0;
    clearInputs();
    checkOutput("midRstPc", bus.pc, RESET_PC);
    checkOutput("midRstInstr", bus.instr, 32'h0);
    checkOutput("midRstCount", bus.retired_count, 32'd0);
    checkOutput("midRstFlags", {30'd0, bus.imem_req, bus.instr_valid}, 32'h0);
    expAddrQ.push_back(RESET_PC);
    stepClk();
    checkOutput("idleOneCycle", 32'(bus.imem_req), 32'd1);
    fetchInstr("fE2", 32'h0000_006F, 1'b1);

    // Wrap: JAL -4 from 0 lands at the top word, then +4 wraps to 0.
    applyStimulus("toTop", 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'hFFFF_FFFC);
    fetchInstr("fTop", 32'h0000_0013, 1'b1);
    checkOutput("wrapLink", bus.link_addr, 32'h0);
    applyStimulus("wrap", 0, 0, 0, 0, 0, 32'h0, 32'h0, 1'b1, 32'h0);
    fetchInstr("fWrap", 32'h0000_0013, 1'b1);
    checkOutput("wrapCount", bus.retired_count, 32'd2);

    checkOutput("sbDrained", 32'(expAddrQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
